// File: rtl/gan_inference_sequencer_pkg.sv
// Shared types and constants for the GAN inference sequencer slice.
package gan_seq_pkg;

  localparam int NUM_WORDS      = 10;
  localparam int IDX_W          = 4;
  localparam int Q15_W          = 16;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } seq_state_e;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_WORDS - 1);
  endfunction

endpackage

// File: rtl/gan_inference_sequencer_if.sv
// Noise input stream, GAN core port bundle and result output stream.
interface gan_inference_sequencer_if #(
  parameter int DATA_W = 16
);
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_W-1:0]               in_noise_0;
  logic [DATA_W-1:0]               in_noise_1;
  logic                            core_start;
  logic [DATA_W-1:0]               core_noise_0;
  logic [DATA_W-1:0]               core_noise_1;
  logic [DATA_W-1:0]               core_gen_image_0;
  logic [DATA_W-1:0]               core_gen_image_1;
  logic [DATA_W-1:0]               core_gen_image_2;
  logic [DATA_W-1:0]               core_gen_image_3;
  logic [DATA_W-1:0]               core_gen_image_4;
  logic [DATA_W-1:0]               core_gen_image_5;
  logic [DATA_W-1:0]               core_gen_image_6;
  logic [DATA_W-1:0]               core_gen_image_7;
  logic [DATA_W-1:0]               core_gen_image_8;
  logic [DATA_W-1:0]               core_disc_prob;
  logic                            core_done;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_W-1:0]               out_data;
  logic [gan_seq_pkg::IDX_W-1:0]   out_index;
  logic                            out_last;

  // Sequencer side
  modport master (
    input  in_valid, in_noise_0, in_noise_1,
    input  core_gen_image_0, core_gen_image_1, core_gen_image_2,
    input  core_gen_image_3, core_gen_image_4, core_gen_image_5,
    input  core_gen_image_6, core_gen_image_7, core_gen_image_8,
    input  core_disc_prob, core_done, out_ready,
    output in_ready, core_start, core_noise_0, core_noise_1,
    output out_valid, out_data, out_index, out_last
  );

  // Host, core and sink side
  modport slave (
    output in_valid, in_noise_0, in_noise_1,
    output core_gen_image_0, core_gen_image_1, core_gen_image_2,
    output core_gen_image_3, core_gen_image_4, core_gen_image_5,
    output core_gen_image_6, core_gen_image_7, core_gen_image_8,
    output core_disc_prob, core_done, out_ready,
    input  in_ready, core_start, core_noise_0, core_noise_1,
    input  out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/gan_inference_sequencer_serializer.sv
// Captures one 10-word GAN result and streams it out with valid/ready,
// holding data and index stable while the sink stalls.
module gan_result_serializer
  import gan_seq_pkg::*;
#(
  parameter int DATA_W = Q15_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [NUM_WORDS-1:0][DATA_W-1:0] words,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  output logic [IDX_W-1:0]                out_index,
  output logic                            out_last,
  output logic                            last_accepted
);

  logic [NUM_WORDS-1:0][DATA_W-1:0] cap_r;
  logic                             valid_r;
  logic                             last_r;
  logic [DATA_W-1:0]                data_r;
  logic [IDX_W-1:0]                 idx_r;
  logic [IDX_W-1:0]                 next_idx_s;
  logic                             accept_s;

  assign accept_s      = valid_r & out_ready;
  assign next_idx_s    = idx_r + IDX_W'(1);
  assign last_accepted = accept_s & is_last_idx(idx_r);

  // Capture buffer, index counter and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
      idx_r   <= '0;
    end else if (load) begin
      cap_r   <= words;
      valid_r <= 1'b1;
      last_r  <= 1'b0;
      data_r  <= words[0];
      idx_r   <= '0;
    end else if (accept_s) begin
      if (is_last_idx(idx_r)) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
        data_r  <= '0;
        idx_r   <= '0;
      end else begin
        idx_r   <= next_idx_s;
        data_r  <= cap_r[next_idx_s];
        last_r  <= is_last_idx(next_idx_s);
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_index = idx_r;
  assign out_last  = last_r;

endmodule

// File: rtl/gan_inference_sequencer.sv
// Issues one GAN core inference per accepted noise pair, waits for done with
// a timeout, and hands the captured image/probability to the serializer.
module gan_inference_sequencer
  import gan_seq_pkg::*;
#(
  parameter int DATA_W         = Q15_W,
  parameter int TIMEOUT_CYCLES = gan_seq_pkg::TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gan_inference_sequencer_if.master bus,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [15:0]               sample_count
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e                       state_r;
  logic                             core_start_r;
  logic [DATA_W-1:0]                noise_0_r;
  logic [DATA_W-1:0]                noise_1_r;
  logic                             busy_r;
  logic                             timeout_err_r;
  logic [15:0]                      sample_count_r;
  logic [CNT_W-1:0]                 cnt_r;
  logic                             load_s;
  logic                             last_accepted_s;
  logic [NUM_WORDS-1:0][DATA_W-1:0] words_s;
  logic                             out_valid_s;
  logic [DATA_W-1:0]                out_data_s;
  logic [IDX_W-1:0]                 out_index_s;
  logic                             out_last_s;

  assign load_s  = (state_r == ST_WAIT) & bus.core_done;
  assign words_s = {bus.core_disc_prob,
                    bus.core_gen_image_8, bus.core_gen_image_7, bus.core_gen_image_6,
                    bus.core_gen_image_5, bus.core_gen_image_4, bus.core_gen_image_3,
                    bus.core_gen_image_2, bus.core_gen_image_1, bus.core_gen_image_0};

  // Sequencer FSM with noise latch, timeout counter and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      core_start_r   <= 1'b0;
      noise_0_r      <= '0;
      noise_1_r      <= '0;
      busy_r         <= 1'b0;
      timeout_err_r  <= 1'b0;
      sample_count_r <= 16'd0;
      cnt_r          <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            noise_0_r    <= bus.in_noise_0;
            noise_1_r    <= bus.in_noise_1;
            cnt_r        <= '0;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ST_START;
          end
        end
        ST_START: begin
          core_start_r <= 1'b0;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over a timeout landing on the same cycle
          if (bus.core_done) begin
            state_r <= ST_SEND;
          end else if (cnt_r == CNT_LAST) begin
            timeout_err_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (last_accepted_s) begin
            sample_count_r <= sample_count_r + 16'd1;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        default: begin
          core_start_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  gan_result_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load_s),
    .words         (words_s),
    .out_ready     (bus.out_ready),
    .out_valid     (out_valid_s),
    .out_data      (out_data_s),
    .out_index     (out_index_s),
    .out_last      (out_last_s),
    .last_accepted (last_accepted_s)
  );

  assign bus.in_ready     = (state_r == ST_IDLE);
  assign bus.core_start   = core_start_r;
  assign bus.core_noise_0 = noise_0_r;
  assign bus.core_noise_1 = noise_1_r;
  assign bus.out_valid    = out_valid_s;
  assign bus.out_data     = out_data_s;
  assign bus.out_index    = out_index_s;
  assign bus.out_last     = out_last_s;
  assign busy             = busy_r;
  assign timeout_err      = timeout_err_r;
  assign sample_count     = sample_count_r;

endmodule
